// File: rtl/fp_div_unit_if.sv
// Shared FPU slot types and the operand/result bundle between the divider and its issuer.
package Modules_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        BUSY = 2'd1
    } fu_state_e;

    localparam int unsigned BIAS = 127;
endpackage

interface fp_div_unit_if;
    import Modules_pkg::*;

    logic      start_i;
    float_t    dividend_i;
    float_t    divisor_i;
    float_t    to_round_unit_o;
    logic      valid_o;
    fu_state_e fu_state_o;
    logic      overflow_o;
    logic      underflow_o;
    logic      invalid_op_o;
    logic      div_by_zero_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  to_round_unit_o, valid_o, fu_state_o,
        input  overflow_o, underflow_o, invalid_op_o, div_by_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output to_round_unit_o, valid_o, fu_state_o,
        output overflow_o, underflow_o, invalid_op_o, div_by_zero_o
    );
endinterface

// File: rtl/fp_div_unit.sv
// Multi-cycle single-precision divider: special-case screening, 26-step restoring
// mantissa division, then normalisation with round-half-up into the round-unit slot.
module fp_div_unit
    import Modules_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    fp_div_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PREPARE,
        DIVIDE,
        NORMALIZE,
        VALID
    } state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_e             state_q, state_d;
    float_t             a_q, a_d;
    float_t             b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [25:0]        quot_q, quot_d;
    logic [4:0]         cnt_q, cnt_d;
    float_t             result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inv_q, inv_d;
    logic               dbz_q, dbz_d;

    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;
    logic               res_sign;
    logic               trial_ok;
    logic [23:0]        trial_rem;
    logic [22:0]        norm_mant;
    logic               norm_guard;
    logic [23:0]        rounded;
    logic signed [9:0]  norm_exp;

    // Denormals share exponent 0 with true zero, so they are flushed to zero here.
    assign a_zero   = (a_q.exponent == 8'd0);
    assign a_inf    = (a_q.exponent == 8'hFF) && (a_q.mantissa == 23'd0);
    assign a_nan    = (a_q.exponent == 8'hFF) && (a_q.mantissa != 23'd0);
    assign b_zero   = (b_q.exponent == 8'd0);
    assign b_inf    = (b_q.exponent == 8'hFF) && (b_q.mantissa == 23'd0);
    assign b_nan    = (b_q.exponent == 8'hFF) && (b_q.mantissa != 23'd0);
    assign res_sign = a_q.sign ^ b_q.sign;

    assign trial_ok  = (rem_q >= {1'b0, div_q});
    assign trial_rem = rem_q[23:0] - div_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        dbz_d    = dbz_q;

        norm_mant  = quot_q[24:2];
        norm_guard = quot_q[1];
        norm_exp   = exp_q;
        rounded    = 24'd0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.dividend_i;
                    b_d     = bus.divisor_i;
                    state_d = PREPARE;
                end
            end

            PREPARE: begin
                sign_d  = res_sign;
                exp_d   = 10'({2'b00, a_q.exponent}) - 10'({2'b00, b_q.exponent}) + 10'(BIAS);
                rem_d   = {2'b01, a_q.mantissa};
                div_d   = {1'b1, b_q.mantissa};
                quot_d  = 26'd0;
                cnt_d   = 5'd0;
                state_d = DIVIDE;

                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = QNAN;
                    {ovf_d, unf_d, inv_d, dbz_d} = 4'b0010;
                    state_d  = VALID;
                end else if (b_zero && !a_inf) begin
                    result_d = {res_sign, 8'hFF, 23'd0};
                    {ovf_d, unf_d, inv_d, dbz_d} = 4'b0001;
                    state_d  = VALID;
                end else if (a_inf) begin
                    result_d = {res_sign, 8'hFF, 23'd0};
                    {ovf_d, unf_d, inv_d, dbz_d} = 4'b0000;
                    state_d  = VALID;
                end else if (a_zero || b_inf) begin
                    result_d = {res_sign, 31'd0};
                    {ovf_d, unf_d, inv_d, dbz_d} = 4'b0000;
                    state_d  = VALID;
                end
            end

            DIVIDE: begin
                rem_d  = trial_ok ? {trial_rem, 1'b0} : {rem_q[23:0], 1'b0};
                quot_d = {quot_q[24:0], trial_ok};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = NORMALIZE;
                end
            end

            NORMALIZE: begin
                // The quotient lies in [1,2) or [0.5,1); the latter needs one left shift.
                if (!quot_q[25]) begin
                    norm_mant  = quot_q[23:1];
                    norm_guard = quot_q[0];
                    norm_exp   = exp_q - 10'sd1;
                end
                rounded = {1'b0, norm_mant} + {23'd0, norm_guard};
                if (rounded[23]) begin
                    norm_exp = norm_exp + 10'sd1;
                end

                {ovf_d, unf_d, inv_d, dbz_d} = 4'b0000;
                if (norm_exp >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (norm_exp <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, norm_exp[7:0], rounded[22:0]};
                end
                state_d = VALID;
            end

            VALID: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset wins over the clock enable so a stalled unit can still be aborted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.to_round_unit_o = result_q;
    assign bus.valid_o         = (state_q == VALID);
    assign bus.fu_state_o      = (state_q == IDLE) ? FREE : BUSY;
    assign bus.overflow_o      = ovf_q;
    assign bus.underflow_o     = unf_q;
    assign bus.invalid_op_o    = inv_q;
    assign bus.div_by_zero_o   = dbz_q;

endmodule

// File: tb/tb_fp_div_unit.sv
// Self-checking bench for fp_div_unit: table of operand pairs through a scoreboard,
// plus hand-written stall, busy-start and mid-operation reset sequences.
module tb_fp_div_unit;
    import Modules_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   cyc = 0;
    int   start_cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    vec_t vecs[$];
    exp_t sb[$];

    fp_div_unit_if bus();

    fp_div_unit dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] flagsNow();
        return {bus.overflow_o, bus.underflow_o, bus.invalid_op_o, bus.div_by_zero_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                          input logic [3:0] flags, input int lat, input string name);
        vec_t v;
        v.a = a; v.b = b; v.res = res; v.flags = flags; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the PREPARE cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                 input logic [3:0] flags, input int lat, input string name);
        exp_t e;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.start_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_i    = 1'b0;
        bus.dividend_i = 32'hDEAD_BEEF;
        bus.divisor_i  = 32'h1234_5678;
        start_cyc      = cyc;
        e.res = res; e.flags = flags; e.lat = lat; e.name = name;
        sb.push_back(e);
        check({name, "_busy"}, 32'(bus.fu_state_o), 32'(BUSY));
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkOutput();
        bit   ok;
        exp_t e;
        waitValid(ok);
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got valid_o=%0b, expected a queued result", ok);
            return;
        end
        e = sb.pop_front();
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: got no valid_o in 300 cycles, expected one", e.name);
            return;
        end
        check({e.name, "_result"},  bus.to_round_unit_o, e.res);
        check({e.name, "_flags"},   32'(flagsNow()), 32'(e.flags));
        check({e.name, "_latency"}, 32'(cyc - start_cyc + 1), 32'(e.lat));
        @(negedge clk);
        check({e.name, "_valid_drop"}, 32'(bus.valid_o), 32'd0);
        check({e.name, "_free"},       32'(bus.fu_state_o), 32'(FREE));
    endtask

    task automatic expectQuiet(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        clk_en         = 1'b1;
        bus.start_i    = 1'b0;
        bus.dividend_i = 32'd0;
        bus.divisor_i  = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_result", bus.to_round_unit_o, 32'd0);
        check("reset_flags",  32'(flagsNow()), 32'd0);
        check("reset_valid",  32'(bus.valid_o), 32'd0);
        check("reset_free",   32'(bus.fu_state_o), 32'(FREE));

        //     dividend      divisor       result        {ovf,unf,inv,dbz} lat
        addVec(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "six_by_two");
        addVec(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 29, "neg_six_by_two");
        addVec(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29, "one_by_three");
        addVec(32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 4'b0000, 29, "one_by_1p5");
        addVec(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 29, "max_by_one");
        addVec(32'h7F000000, 32'h00800000, 32'h7F800000, 4'b1000, 29, "overflow");
        addVec(32'h00800000, 32'h7F000000, 32'h00000000, 4'b0100, 29, "underflow");
        addVec(32'hFF000000, 32'h00800000, 32'hFF800000, 4'b1000, 29, "neg_overflow");
        addVec(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001,  2, "one_by_zero");
        addVec(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001,  2, "neg_one_by_zero");
        addVec(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010,  2, "zero_by_zero");
        addVec(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0010,  2, "inf_by_inf");
        addVec(32'h3F800000, 32'h7F800001, 32'h7FC00000, 4'b0010,  2, "nan_divisor");
        addVec(32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000,  2, "inf_by_zero");
        addVec(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000,  2, "neg_inf_by_two");
        addVec(32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000,  2, "two_by_neg_inf");
        addVec(32'h00400000, 32'h40000000, 32'h00000000, 4'b0000,  2, "denormal_flush");
        addVec(32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000,  2, "zero_by_neg_three");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, vecs[i].lat, vecs[i].name);
            checkOutput();
        end

        // Five disabled cycles in the middle of DIVIDE push valid_o out to T+34.
        applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 34, "stall");
        repeat (10) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        checkOutput();

        // A second start while busy must not replace the operands or queue another result.
        applyStimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29, "busy_start");
        repeat (4) @(negedge clk);
        bus.dividend_i = 32'h40C00000;
        bus.divisor_i  = 32'h40000000;
        bus.start_i    = 1'b1;
        @(negedge clk);
        bus.start_i    = 1'b0;
        checkOutput();
        expectQuiet("busy_start_no_extra_valid", 40);

        // Reset at T+10 aborts the divide and clears the held 1/3 result.
        applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "aborted");
        sb.delete(sb.size() - 1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_free",   32'(bus.fu_state_o), 32'(FREE));
        check("abort_valid",  32'(bus.valid_o), 32'd0);
        check("abort_result", bus.to_round_unit_o, 32'd0);
        check("abort_flags",  32'(flagsNow()), 32'd0);
        expectQuiet("abort_no_valid", 40);

        applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "after_reset");
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
